// File: rtl/stch2dec_window.sv
// Purpose: stochastic bitstream to ND-bit decimal, counts ones over 2^NW EN-qualified samples.
// Latency: D/V update on the edge taking the 2^NW-th sample, visible the following cycle.
// Backpressure: none; EN stalls the window and V is a single-cycle strobe with no hold-off.
module stch2dec_window #(
    parameter int ND = 8,
    parameter int NW = 8
) (
    input  logic          CLK,
    input  logic          INIT,
    input  logic          START,
    input  logic          CONT,
    input  logic          EN,
    input  logic          S,
    output logic [ND-1:0] D,
    output logic          V,
    output logic          BUSY
);

    // A window shorter than the output precision cannot fill D.
    if (NW < ND) begin : g_bad_params
        $error("stch2dec_window: NW must be >= ND");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int SH = NW - ND;
    localparam logic [NW-1:0] NCYC_ONE = 1;

    state_t        state;
    // One extra bit so an all-ones window (2^NW) is representable.
    logic [NW:0]   ones;
    logic [NW-1:0] ncyc;
    logic [NW:0]   total;
    logic [NW:0]   scaled;

    // Running count including the sample on the current edge.
    assign total  = ones + {{NW{1'b0}}, S};
    assign scaled = total >> SH;

    // Window FSM: IDLE waits for START, COUNT accumulates and closes after 2^NW samples.
    always_ff @(posedge CLK) begin
        if (!INIT) begin
            state <= IDLE;
            ones  <= '0;
            ncyc  <= '0;
            D     <= '0;
            V     <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            V <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state <= COUNT;
                        BUSY  <= 1'b1;
                        ones  <= '0;
                        ncyc  <= '0;
                    end
                end
                COUNT: begin
                    if (EN) begin
                        if (ncyc == '1) begin
                            // 2^NW would shift to 2^ND, so clamp to the largest code.
                            D    <= (|scaled[NW:ND]) ? '1 : scaled[ND-1:0];
                            V    <= 1'b1;
                            ones <= '0;
                            ncyc <= '0;
                            if (CONT) begin
                                state <= COUNT;
                                BUSY  <= 1'b1;
                            end else begin
                                state <= IDLE;
                                BUSY  <= 1'b0;
                            end
                        end else begin
                            ones <= total;
                            ncyc <= ncyc + NCYC_ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/stch2dec_window.md
Name: stch2dec_window

Overview:
- Converts a single-bit stochastic stream back to an ND-bit decimal probability scaled to x/2^ND.
- It is the inverse of the decimal-to-stochastic comparator converter.
- Counts ones over a fixed window of 2^NW valid samples and registers the scaled count with a one-cycle valid strobe.
- Sits at stochastic network outputs and in loopback checkers, where results feed back into binary logic.

Parameters:
- ND, 8, output precision in bits; result scaled to x/2^ND.
- NW, 8, log2 of window length in valid samples; NW >= ND is required (elaboration error otherwise).

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- INIT  input  1  synchronous, active-low reset.
- START  input  1  begin a window; honoured only in IDLE.
- CONT  input  1  continuous mode; sampled at window close.
- EN  input  1  sample qualifier; S is counted only on cycles with EN=1.
- S  input  1  stochastic bit.
- D  output  ND  decimal result, registered.
- V  output  1  result-valid strobe, one cycle wide.
- BUSY  output  1  high while in COUNT.

Behaviour:
- Reset (INIT=0 at a posedge):
  - state=IDLE; D=0; V=0; BUSY=0.
  - Ones counter and sample counter cleared.
  - An in-progress window is discarded and produces no V.
- Internal counters:
  - ones: NW+1 bits, so it can hold 2^NW.
  - ncyc: NW bits.
- Default: V deasserts every cycle unless set by a window close.
- IDLE:
  - BUSY=0.
  - START=1 at an edge: state <= COUNT; ones and ncyc cleared. S is not sampled on that edge.
- COUNT:
  - BUSY=1.
  - Each edge with EN=1 and ncyc != 2^NW-1: ones <= ones+S; ncyc <= ncyc+1.
  - EN=0: no change to any counter; state holds.
  - START is ignored.
- Window close (edge with EN=1 and ncyc == 2^NW-1):
  - total = ones+S.
  - D <= total >> (NW-ND), saturated to 2^ND-1 (all-ones input gives 2^ND-1, not 0).
  - V <= 1. Counters cleared.
  - State <= COUNT if CONT=1, else IDLE.
- Continuous mode: with CONT=1 the next window's first sample is taken on the very next edge, with zero gap between windows.
- Latency:
  - START accepted at edge t0; with EN held at 1, samples are taken at edges t0+1 .. t0+2^NW.
  - D and V update at edge t0+2^NW and are visible in the following cycle.
- D holds its last result until the next window close; V does not re-fire.
- CONT changes mid-window take effect only at the close.
- Simultaneous START with window close is ignored; CONT alone decides the next state.

Test Plan:
- ND=8, NW=8, START, EN=1, S=0 for 256 cycles -> V pulses once exactly 256 edges after START, D=0, BUSY falls the same edge.
- S=1 constant, same setup -> D=255 (saturated), V one cycle.
- S alternating 1,0, ND=4, NW=8 -> D=8 (128>>4), V single-cycle.
- CONT=1, S window A all ones then window B alternating, ND=NW=8 -> two V pulses exactly 256 cycles apart, D=255 then 128, no dropped sample at the boundary.
- EN toggled 1,0 with S=1 on every cycle, NW=4 -> 16 valid samples span 32 cycles, D=2^ND-1, V on the 16th EN=1 edge.
- INIT=0 asserted at sample 100 of 256, then START, S all zero -> no V from the aborted window, D=0, next V exactly 256 edges after the new START.
